// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads opcode/operand bytes from the
// registered-output RAM and hands complete instructions over valid/ready.
module fetch_unit #(
    parameter logic [7:0]  RESET_PC     = 8'h00,
    parameter logic [15:0] OPERAND_MASK = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       halt,
    input  logic       jump_en,
    input  logic [7:0] jump_addr,
    output logic       mem_read,
    output logic [7:0] mem_address,
    input  logic [7:0] mem_out,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr,
    output logic [7:0] operand,
    output logic [7:0] instr_pc,
    output logic [7:0] pc,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_OP,
        S_CAP_OP,
        S_REQ_ARG,
        S_CAP_ARG,
        S_VALID
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_instr;
    logic [7:0] r_operand;
    logic [7:0] r_instr_pc;
    logic       w_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 8'h00;
            r_operand  <= 8'h00;
            r_instr_pc <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // A start wins over a same-cycle jump: fetch uses the old pc.
                    if (start && !halt) begin
                        r_state <= S_REQ_OP;
                    end else if (jump_en) begin
                        r_pc <= jump_addr;
                    end
                end
                S_REQ_OP: begin
                    r_instr_pc <= r_pc;
                    r_pc       <= r_pc + 8'd1;
                    r_state    <= S_CAP_OP;
                end
                S_CAP_OP: begin
                    r_instr   <= mem_out;
                    r_operand <= 8'h00;
                    if (OPERAND_MASK[mem_out[7:4]]) begin
                        r_state <= S_REQ_ARG;
                    end else begin
                        r_state <= S_VALID;
                    end
                end
                S_REQ_ARG: begin
                    r_pc    <= r_pc + 8'd1;
                    r_state <= S_CAP_ARG;
                end
                S_CAP_ARG: begin
                    r_operand <= mem_out;
                    r_state   <= S_VALID;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        if (jump_en) begin
                            r_pc <= jump_addr;
                        end
                        r_state <= halt ? S_IDLE : S_REQ_OP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_req       = (r_state == S_REQ_OP) || (r_state == S_REQ_ARG);
    assign mem_read    = w_req;
    assign mem_address = w_req ? r_pc : 8'h00;
    assign instr_valid = (r_state == S_VALID);
    assign busy        = (r_state != S_IDLE);
    assign instr       = r_instr;
    assign operand     = r_operand;
    assign instr_pc    = r_instr_pc;
    assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 256x8 registered-output RAM.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       halt;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       mem_read;
    logic [7:0] mem_address;
    logic [7:0] mem_out;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] operand;
    logic [7:0] instr_pc;
    logic [7:0] pc;
    logic       busy;

    logic [7:0] ram [0:255];
    int         n_checks = 0;
    int         n_errors = 0;
    int         seen_valid;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC    (8'h00),
        .OPERAND_MASK(16'h0008)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .mem_read   (mem_read),
        .mem_address(mem_address),
        .mem_out    (mem_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .operand    (operand),
        .instr_pc   (instr_pc),
        .pc         (pc),
        .busy       (busy)
    );

    always_ff @(posedge clk) begin
        if (mem_read) begin
            mem_out <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        mem_out     = 8'h00;
        rst         = 1'b1;
        start       = 1'b0;
        halt        = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = 8'h00;
        instr_ready = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_valid", 8'(instr_valid), 8'h00);
        check("rst_mrd", 8'(mem_read), 8'h00);
        check("rst_addr", mem_address, 8'h00);
        check("rst_instr", instr, 8'h00);
        check("rst_ipc", instr_pc, 8'h00);
        rst = 1'b0;

        // T1: one-byte opcode, latency 3
        ram[8'h00] = 8'h12;
        ram[8'h01] = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_mrd", 8'(mem_read), 8'h01);
        check("t1_addr", mem_address, 8'h00);
        check("t1_busy", 8'(busy), 8'h01);
        tick();
        check("t1_c2_valid", 8'(instr_valid), 8'h00);
        check("t1_c2_mrd", 8'(mem_read), 8'h00);
        tick();
        check("t1_valid", 8'(instr_valid), 8'h01);
        check("t1_instr", instr, 8'h12);
        check("t1_oper", operand, 8'h00);
        check("t1_ipc", instr_pc, 8'h00);
        check("t1_pc", pc, 8'h01);

        // T3: stall in VALID for 4 cycles, then release
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_valid", 8'(instr_valid), 8'h01);
            check("t3_instr", instr, 8'h12);
            check("t3_mrd", 8'(mem_read), 8'h00);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t3_next_mrd", 8'(mem_read), 8'h01);
        check("t3_next_addr", mem_address, 8'h01);
        check("t3_next_valid", 8'(instr_valid), 8'h00);
        tick();
        tick();
        check("t3_instr2", instr, 8'h20);
        check("t3_ipc2", instr_pc, 8'h01);
        check("t3_pc2", pc, 8'h02);

        // T4: jump at the handshake, then jump plus halt
        ram[8'h40] = 8'h05;
        instr_ready = 1'b1;
        jump_en     = 1'b1;
        jump_addr   = 8'h40;
        tick();
        instr_ready = 1'b0;
        jump_en     = 1'b0;
        check("t4_addr", mem_address, 8'h40);
        tick();
        tick();
        check("t4_valid", 8'(instr_valid), 8'h01);
        check("t4_instr", instr, 8'h05);
        check("t4_ipc", instr_pc, 8'h40);
        check("t4_pc", pc, 8'h41);
        instr_ready = 1'b1;
        jump_en     = 1'b1;
        halt        = 1'b1;
        tick();
        instr_ready = 1'b0;
        jump_en     = 1'b0;
        halt        = 1'b0;
        check("t4_h_busy", 8'(busy), 8'h00);
        check("t4_h_pc", pc, 8'h40);
        check("t4_h_mrd", 8'(mem_read), 8'h00);
        check("t4_h_valid", 8'(instr_valid), 8'h00);

        // T2: two-byte opcode from reset pc, jump mid-fetch ignored
        rst = 1'b1;
        #1;
        check("t2_rst_pc", pc, 8'h00);
        tick();
        rst = 1'b0;
        ram[8'h00] = 8'h3A;
        ram[8'h01] = 8'h77;
        start = 1'b1;
        tick();
        start     = 1'b0;
        jump_en   = 1'b1;
        jump_addr = 8'hAA;
        tick();
        jump_en = 1'b0;
        tick();
        check("t2_arg_mrd", 8'(mem_read), 8'h01);
        check("t2_arg_addr", mem_address, 8'h01);
        tick();
        check("t2_c4_valid", 8'(instr_valid), 8'h00);
        tick();
        check("t2_valid", 8'(instr_valid), 8'h01);
        check("t2_instr", instr, 8'h3A);
        check("t2_oper", operand, 8'h77);
        check("t2_ipc", instr_pc, 8'h00);
        check("t2_pc", pc, 8'h02);
        instr_ready = 1'b1;
        halt        = 1'b1;
        tick();
        instr_ready = 1'b0;
        halt        = 1'b0;
        check("t2_idle", 8'(busy), 8'h00);

        // T5: operand fetch wraps FF -> 00
        ram[8'hFF] = 8'h35;
        ram[8'h00] = 8'h99;
        jump_en   = 1'b1;
        jump_addr = 8'hFF;
        tick();
        jump_en = 1'b0;
        check("t5_jpc", pc, 8'hFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_addr", mem_address, 8'hFF);
        for (int i = 0; i < 4; i++) tick();
        check("t5_valid", 8'(instr_valid), 8'h01);
        check("t5_instr", instr, 8'h35);
        check("t5_oper", operand, 8'h99);
        check("t5_ipc", instr_pc, 8'hFF);
        check("t5_pc", pc, 8'h01);
        instr_ready = 1'b1;
        halt        = 1'b1;
        tick();
        instr_ready = 1'b0;

        // halt in IDLE blocks start
        start = 1'b1;
        tick();
        start = 1'b0;
        halt  = 1'b0;
        check("hold_busy", 8'(busy), 8'h00);
        check("hold_mrd", 8'(mem_read), 8'h00);

        // T6: reset asserted in CAP_ARG aborts the fetch
        ram[8'h01] = 8'h3C;
        ram[8'h02] = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("t6_pre_pc", pc, 8'h03);
        rst = 1'b1;
        #1;
        check("t6_mrd", 8'(mem_read), 8'h00);
        check("t6_valid", 8'(instr_valid), 8'h00);
        check("t6_pc", pc, 8'h00);
        check("t6_busy", 8'(busy), 8'h00);
        tick();
        rst = 1'b0;
        instr_ready = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (instr_valid) seen_valid++;
        end
        instr_ready = 1'b0;
        check("t6_no_valid", 8'(seen_valid), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
